rr_csel_arbiter8: RTL and testbench

Eight-way round-robin arbiter for a shared resource with active-low chip selects. It samples eight request lines, grants one requester at a time, and holds the grant until the owner signals done, drops its request, or exceeds a programmable hold limit. It drives both an active-low one-hot select bus and the encoded 3-bit index, so it can front the 3-to-8 chip-select decode path or replace it.

---
 rtl/rr_csel_arbiter8.sv | 95 +++++++++
 tb/tb_rr_csel_arbiter8.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_csel_arbiter8.sv
// rtl/rr_csel_arbiter8.sv - eight-way round-robin arbiter with active-low one-hot selects and hold limit
module rr_csel_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt_n,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] cnt;
    logic [2:0] pick;

    // First set request at or after ptr, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] sel;
        logic [2:0] cand;
        logic       found;
        sel   = p;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cand = p + 3'(k);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(req, ptr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= 8'd0;
            gnt_n     <= 8'hFF;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= GRANT;
                        gnt_idx   <= pick;
                        gnt_n     <= ~(8'h01 << pick);
                        gnt_valid <= 1'b1;
                        cnt       <= 8'd0;
                    end
                end
                GRANT: begin
                    // done outranks the hold limit, so a coincident done never pulses timeout.
                    if (done || !req[gnt_idx]) begin
                        state     <= IDLE;
                        gnt_n     <= 8'hFF;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 3'd1;
                    end else if (HOLD_EN && (cnt == HOLD_LAST)) begin
                        state     <= IDLE;
                        gnt_n     <= 8'hFF;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 3'd1;
                        timeout   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~gnt_n));
    a_valid_match: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (gnt_n != 8'hFF));

endmodule

// File: tb/tb_rr_csel_arbiter8.sv
// tb/tb_rr_csel_arbiter8.sv - randomized and directed checks of rr_csel_arbiter8 against a queue-free reference model
module tb_rr_csel_arbiter8;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt_n;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp;
    int n_bad;

    // Reference model: owner is -1 when nobody holds the resource.
    int m_owner;
    int m_last;
    int m_ptr;
    int m_held;
    int m_timeout;

    rr_csel_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_n     (gnt_n),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic release_owner(input int forced);
        m_timeout = forced;
        m_ptr     = (m_owner + 1) % 8;
        m_owner   = -1;
    endtask

    task automatic tick();
        int n;
        @(posedge clk);
        if (!rst_n) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_timeout = 0;
        end else if (m_owner < 0) begin
            m_timeout = 0;
            for (int k = 0; k < 8; k++) begin
                n = (m_ptr + k) % 8;
                if (m_owner < 0 && req[n]) begin
                    m_owner = n; m_last = n; m_held = 1;
                end
            end
        end else begin
            if (done || !req[m_owner]) release_owner(0);
            else if (MH != 0 && m_held == MH) release_owner(1);
            else m_held++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 8'h00; done = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'hFF; done = 1'b0;
        tick(); tick();
        n_cmp++;
        if (gnt_n !== 8'hFF || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: gnt_n=%h valid=%b timeout=%b, want ff 0 0", gnt_n, gnt_valid, timeout);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (gnt_idx !== 3'd0 || gnt_n !== 8'hFE || gnt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_grant: idx=%0d gnt_n=%h valid=%b, want 0 fe 1", gnt_idx, gnt_n, gnt_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h20;
        tick();
        n_cmp++;
        if (gnt_n !== 8'hDF || gnt_idx !== 3'd5 || gnt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_grant: gnt_n=%h idx=%0d valid=%b, want df 5 1", gnt_n, gnt_idx, gnt_valid);
        end
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt_n !== 8'hFF || gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 3'd5) begin
            n_bad++;
            $display("FAIL single_release: gnt_n=%h valid=%b timeout=%b idx=%0d, want ff 0 0 5", gnt_n, gnt_valid, timeout, gnt_idx);
        end
        tick();
        n_cmp++;
        if (gnt_n !== 8'hDF || gnt_idx !== 3'd5) begin
            n_bad++;
            $display("FAIL single_regrant: gnt_n=%h idx=%0d, want df 5", gnt_n, gnt_idx);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] want;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            want = 8'hFF;
            want[i % 8] = 1'b0;
            n_cmp++;
            if (gnt_idx !== 3'(i % 8) || gnt_n !== want) begin
                n_bad++;
                $display("FAIL rotation_owner[%0d]: idx=%0d gnt_n=%h, want %0d %h", i, gnt_idx, gnt_n, i % 8, want);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            n_cmp++;
            if (gnt_n !== 8'hFF) begin
                n_bad++;
                $display("FAIL rotation_gap[%0d]: gnt_n=%h, want ff", i, gnt_n);
            end
        end
    endtask

    task automatic test_timeout();
        int valid_cycles;
        do_reset();
        req = 8'h01;
        valid_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (gnt_valid === 1'b1) valid_cycles++;
        end
        n_cmp++;
        if (valid_cycles != MH || gnt_valid !== 1'b0 || timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_forced: valid_cycles=%0d valid=%b timeout=%b, want %0d 0 1", valid_cycles, gnt_valid, timeout, MH);
        end
        tick();
        n_cmp++;
        if (gnt_n !== 8'hFE || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_regrant: gnt_n=%h timeout=%b, want fe 0", gnt_n, timeout);
        end
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_done_wins: valid=%b timeout=%b, want 0 0", gnt_valid, timeout);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_done_no_pulse: timeout=%b, want 0", timeout);
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 8'h18;
        tick(); tick();
        n_cmp++;
        if (gnt_idx !== 3'd3 || gnt_n !== 8'hF7) begin
            n_bad++;
            $display("FAIL drop_owner: idx=%0d gnt_n=%h, want 3 f7", gnt_idx, gnt_n);
        end
        req = 8'h10;
        tick();
        n_cmp++;
        if (gnt_n !== 8'hFF || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_release: gnt_n=%h timeout=%b, want ff 0", gnt_n, timeout);
        end
        tick();
        n_cmp++;
        if (gnt_idx !== 3'd4 || gnt_n !== 8'hEF) begin
            n_bad++;
            $display("FAIL drop_next: idx=%0d gnt_n=%h, want 4 ef", gnt_idx, gnt_n);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'h40;
        tick(); tick();
        rst_n = 1'b0;
        req = 8'hC1;
        tick();
        n_cmp++;
        if (gnt_n !== 8'hFF || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL midreset_clear: gnt_n=%h valid=%b idx=%0d, want ff 0 0", gnt_n, gnt_valid, gnt_idx);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (gnt_idx !== 3'd0 || gnt_n !== 8'hFE) begin
            n_bad++;
            $display("FAIL midreset_next: idx=%0d gnt_n=%h, want 0 fe", gnt_idx, gnt_n);
        end
    endtask

    task automatic test_random();
        logic [7:0] eg;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done  = ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
            eg = 8'hFF;
            if (m_owner >= 0) eg[m_owner] = 1'b0;
            n_cmp++;
            if (gnt_n !== eg || gnt_idx !== 3'(m_last) || gnt_valid !== (m_owner >= 0) || timeout !== 1'(m_timeout)) begin
                n_bad++;
                $display("FAIL random[%0d]: gnt_n=%h idx=%0d valid=%b to=%b, want %h %0d %b %0d",
                         c, gnt_n, gnt_idx, gnt_valid, timeout, eg, m_last, m_owner >= 0, m_timeout);
            end
        end
        rst_n = 1'b1; done = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_timeout = 0;
        rst_n = 1'b0; req = 8'h00; done = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_req_drop();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
